// File: rtl/ptw_pte_port_if.sv
// ptw_pte_port_if: request/grant/valid memory read port between the PTE responder and the data-side arbiter
interface ptw_pte_port_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/ptw_pte_port.sv
// ptw_pte_port: PTE read responder for the Sv39 walker; direct-mapped PTE cache present only with PTW_PTE_CACHE_EN
module ptw_pte_port #(
    parameter int PA_WIDTH = 56,
    parameter int IDX_BITS = 3
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           ren,
    input  logic [63:0]    pa,
    input  logic           flush,
    output logic [63:0]    pte,
    output logic           stall,
    ptw_pte_port_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e      state_q;
    logic        req_q;
    logic [63:0] addr_q;
    logic [63:0] resp_q;
    logic        fill_ok_q;
    logic        hit;
    logic [63:0] hit_data;
    logic        fill;

    // read data is taken in WAIT, or in REQ when grant and data arrive together
    assign fill = (state_q == REQ && mem.mem_gnt && mem.mem_rvalid) || (state_q == WAIT && mem.mem_rvalid);

`ifdef PTW_PTE_CACHE_EN
    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_W   = PA_WIDTH - 3 - IDX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q  [ENTRIES];
    logic [63:0]         data_q [ENTRIES];
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] fill_idx;
    logic                unused_ok;

    assign idx       = pa[3 +: IDX_BITS];
    assign fill_idx  = addr_q[3 +: IDX_BITS];
    assign hit       = valid_q[idx] && tag_q[idx] == pa[PA_WIDTH-1:3+IDX_BITS];
    assign hit_data  = data_q[idx];
    assign unused_ok = ^pa[2:0];

    // valid bits: set by a fill not cancelled by flush; flush clears all after the same-cycle lookup
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) valid_q <= '0;
        else if (flush) valid_q <= '0;
        else if (fill && fill_ok_q) valid_q[fill_idx] <= 1'b1;
    end

    // tag and data storage written together with the valid bit
    always_ff @(posedge clk) begin
        if (fill && fill_ok_q && !flush) begin
            tag_q[fill_idx]  <= addr_q[PA_WIDTH-1:3+IDX_BITS];
            data_q[fill_idx] <= mem.mem_rdata;
        end
    end
`else
    logic unused_ok;

    assign hit       = 1'b0;
    assign hit_data  = '0;
    assign unused_ok = ^{pa[2:0], flush, fill, fill_ok_q};
`endif

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign stall        = state_q == IDLE ? ren && !hit : state_q != RESP;
    assign pte          = (state_q == IDLE && ren && hit) ? hit_data : resp_q;

    // walker request FSM: misses go out on the memory port, the response is presented for one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            resp_q    <= '0;
            fill_ok_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ren && !hit) begin
                    state_q   <= REQ;
                    req_q     <= 1'b1;
                    addr_q    <= {pa[63:3], 3'b000};
                    fill_ok_q <= 1'b1;
                end
                REQ: begin
                    if (flush) fill_ok_q <= 1'b0;
                    if (mem.mem_gnt) begin
                        req_q <= 1'b0;
                        if (mem.mem_rvalid) begin
                            resp_q  <= mem.mem_rdata;
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (flush) fill_ok_q <= 1'b0;
                    if (mem.mem_rvalid) begin
                        resp_q  <= mem.mem_rdata;
                        state_q <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ptw_pte_port.sv
// tb_ptw_pte_port: directed bench for ptw_pte_port, expectations follow PTW_PTE_CACHE_EN when defined
module tb_ptw_pte_port;
    logic        clk   = 1'b0;
    logic        rstn  = 1'b1;
    logic        ren   = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] pa    = '0;
    logic [63:0] pte;
    logic        stall;
    int          checks   = 0;
    int          failures = 0;

    ptw_pte_port_if mem();

    ptw_pte_port dut (
        .clk   (clk),
        .rstn  (rstn),
        .ren   (ren),
        .pa    (pa),
        .flush (flush),
        .pte   (pte),
        .stall (stall),
        .mem   (mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // full miss with immediate grant and one-cycle read data; returns in the RESP cycle
    task automatic miss(input string tag, input logic [63:0] a, input logic [63:0] d);
        ren = 1'b1;
        pa = a;
        mem.mem_gnt = 1'b1;
        mem.mem_rvalid = 1'b0;
        #1;
        check({tag, "_stall_req"}, 64'(stall), 64'd1);
        tick;
        check({tag, "_mem_req"}, 64'(mem.mem_req), 64'd1);
        check({tag, "_mem_addr"}, mem.mem_addr, {a[63:3], 3'b000});
        check({tag, "_stall_reqst"}, 64'(stall), 64'd1);
        tick;
        mem.mem_gnt = 1'b0;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata = d;
        #1;
        check({tag, "_wait_mem_req"}, 64'(mem.mem_req), 64'd0);
        check({tag, "_wait_stall"}, 64'(stall), 64'd1);
        tick;
        mem.mem_rvalid = 1'b0;
        #1;
        check({tag, "_resp_stall"}, 64'(stall), 64'd0);
        check({tag, "_resp_pte"}, pte, d);
    endtask

    initial begin
        mem.mem_gnt = 1'b0;
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata = '0;
        #2 rstn = 1'b0;
        repeat (2) tick;
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_pte", pte, 64'd0);
        check("reset_mem_req", 64'(mem.mem_req), 64'd0);
        check("reset_mem_addr", mem.mem_addr, 64'd0);
        rstn = 1'b1;
        tick;

        miss("miss1", 64'h8000_1008, 64'h2000_0401);

        tick;
        pa = 64'h8000_2010;
        mem.mem_gnt = 1'b1;
        #1;
        check("b2b_stall", 64'(stall), 64'd1);
        check("b2b_idle_mem_req", 64'(mem.mem_req), 64'd0);
        tick;
        check("b2b_mem_req", 64'(mem.mem_req), 64'd1);
        check("b2b_mem_addr", mem.mem_addr, 64'h8000_2010);
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata = 64'h3000_0801;
        tick;
        mem.mem_gnt = 1'b0;
        mem.mem_rvalid = 1'b0;
        ren = 1'b0;
        #1;
        check("b2b_resp_stall", 64'(stall), 64'd0);
        check("b2b_resp_pte", pte, 64'h3000_0801);
        check("b2b_resp_mem_req", 64'(mem.mem_req), 64'd0);
        tick;
        check("hold_pte", pte, 64'h3000_0801);
        check("hold_stall", 64'(stall), 64'd0);

        ren = 1'b1;
        pa = 64'h8000_1008;
`ifdef PTW_PTE_CACHE_EN
        #1;
        check("hit_stall", 64'(stall), 64'd0);
        check("hit_pte", pte, 64'h2000_0401);
        tick;
        check("hit_no_mem_req", 64'(mem.mem_req), 64'd0);
        check("hit_stall_again", 64'(stall), 64'd0);
        ren = 1'b0;
`else
        miss("nocache", 64'h8000_1008, 64'h2000_0402);
        tick;
        ren = 1'b0;
`endif
        tick;

        ren = 1'b1;
        pa = 64'h8000_3018;
        mem.mem_gnt = 1'b1;
        #1;
        check("fl_stall", 64'(stall), 64'd1);
        tick;
        check("fl_mem_req", 64'(mem.mem_req), 64'd1);
        tick;
        mem.mem_gnt = 1'b0;
        flush = 1'b1;
        #1;
        check("fl_wait_stall", 64'(stall), 64'd1);
        tick;
        flush = 1'b0;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata = 64'h4000_0001;
        #1;
        check("fl_wait2_stall", 64'(stall), 64'd1);
        tick;
        mem.mem_rvalid = 1'b0;
        #1;
        check("fl_resp_stall", 64'(stall), 64'd0);
        check("fl_resp_pte", pte, 64'h4000_0001);
        tick;
        check("refetch_stall", 64'(stall), 64'd1);
        tick;
        check("refetch_mem_req", 64'(mem.mem_req), 64'd1);
        check("refetch_mem_addr", mem.mem_addr, 64'h8000_3018);
        mem.mem_gnt = 1'b1;
        tick;
        mem.mem_gnt = 1'b0;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata = 64'h4000_0002;
        tick;
        mem.mem_rvalid = 1'b0;
        #1;
        check("refetch_pte", pte, 64'h4000_0002);
        ren = 1'b0;
        tick;

        ren = 1'b1;
        pa = 64'h8000_4027;
        mem.mem_gnt = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            check("dg_mem_req", 64'(mem.mem_req), 64'd1);
            check("dg_mem_addr", mem.mem_addr, 64'h8000_4020);
            check("dg_stall", 64'(stall), 64'd1);
            tick;
        end
        mem.mem_gnt = 1'b1;
        tick;
        mem.mem_gnt = 1'b0;
        ren = 1'b0;
        #1;
        check("dg_wait_stall", 64'(stall), 64'd1);
        check("dg_wait_mem_req", 64'(mem.mem_req), 64'd0);
        rstn = 1'b0;
        #1;
        check("rst_mem_req", 64'(mem.mem_req), 64'd0);
        check("rst_mem_addr", mem.mem_addr, 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_pte", pte, 64'd0);
        tick;
        rstn = 1'b1;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata = 64'hdead_beef;
        tick;
        mem.mem_rvalid = 1'b0;
        #1;
        check("stray_pte", pte, 64'd0);
        check("stray_stall", 64'(stall), 64'd0);
        check("stray_mem_req", 64'(mem.mem_req), 64'd0);
        ren = 1'b1;
        pa = 64'h8000_5028;
        #1;
        check("post_rst_stall", 64'(stall), 64'd1);
        tick;
        check("post_rst_mem_req", 64'(mem.mem_req), 64'd1);
        check("post_rst_mem_addr", mem.mem_addr, 64'h8000_5028);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
